bp_btb: RTL and testbench
=========================

Name: bp_btb

Overview:
- Parametrised branch predictor for the 5-stage pipeline: direct-mapped branch target buffer with an N-bit saturating direction counter per entry.
- Sits in IF beside the PC adder. It supplies a predicted next PC for the PC mux, so correctly predicted taken branches no longer pay the ID-stage flush.
- ID-stage branch resolution (equality compare plus target adder) feeds the update port.
- Includes wrapping performance counters for branches resolved and mispredicts.

Parameters:
- XLEN, 32, PC/target width.
- ENTRIES, 64, table depth; power of 2, >=2. IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry. Constraint: IDX_W+TAG_W+2 <= XLEN.
- CNT_W, 2, direction counter width, >=1.
- PERF_W, 32, performance counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  invalidate all entries at the next edge.
- pc_i  in  XLEN  IF-stage PC for lookup.
- pred_hit_o  out  1  valid entry with matching tag.
- pred_taken_o  out  1  predicted taken.
- pred_next_pc_o  out  XLEN  predicted next PC.
- upd_valid_i  in  1  a branch resolved in ID this cycle.
- upd_pc_i  in  XLEN  PC of the resolved branch.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  XLEN  actual taken target.
- upd_mispredict_i  in  1  ID detected a mispredict (direction or target).
- br_cnt_o  out  PERF_W  count of cycles with upd_valid_i=1.
- mispred_cnt_o  out  PERF_W  count of cycles with upd_valid_i & upd_mispredict_i.

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - The update port splits upd_pc_i the same way.
- Entry fields: valid, tag[TAG_W], target[XLEN], cnt[CNT_W].
- Lookup is combinational, zero latency, from registered table state:
  - hit = valid[idx] & (tag matches)
  - pred_taken_o = hit & cnt[idx][CNT_W-1]
  - pred_next_pc_o = pred_taken_o ? target[idx] : pc_i+4, modulo 2^XLEN (wraps).
- Update takes effect at the rising edge when upd_valid_i=1:
  - Hit, taken: cnt saturating +1 (max 2^CNT_W-1); target <= upd_target_i.
  - Hit, not taken: cnt saturating -1 (min 0); target unchanged.
  - Miss, taken: allocate (overwrite any aliasing entry). valid=1, tag, target, cnt = 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same idx: lookup returns pre-update contents. No bypass.
- flush_i clears every valid bit at the edge. flush_i has priority over a simultaneous update: the updated entry also ends invalid. Counters and targets are not cleared by flush.
- Perf counters:
  - Increment independently of flush_i.
  - Wrap from 2^PERF_W-1 to 0.
  - Unaffected by update hit/miss.
- Reset (asynchronous, any time including mid-update):
  - All valid=0, tag=0, target=0, cnt = 2^(CNT_W-1)-1 (weakly not taken).
  - br_cnt_o = mispred_cnt_o = 0.
  - Consequence: pred_hit_o=0, pred_taken_o=0, pred_next_pc_o = pc_i+4 while reset is asserted and afterwards until an allocation.
  - An update in the cycle reset deasserts is honoured at the next edge.
- CNT_W=1 degenerates to a last-outcome predictor: allocation sets cnt=1; not-taken sets 0.

Decomposition:
- Package bp_pkg holds:
  - functions clog2, sat_inc(cnt, CNT_W), sat_dec(cnt, CNT_W)
  - localparams for CNT_WEAK_T and CNT_WEAK_NT
  - a typedef for the entry struct, parametrised via the package's width localparams.
- One sub-module, bp_table: the register array. Combinational read port, single synchronous write port, global valid clear, asynchronous reset.
- Top bp_btb holds index/tag extraction, update policy, next-PC mux and perf counters.

Test Plan (defaults: idx=pc[7:2], tag=pc[15:8]):
- Reset, then pc_i=0x100 -> pred_hit_o=0, pred_taken_o=0, pred_next_pc_o=0x104, both perf counters 0.
- Update pc=0x100, taken=1, target=0x80, mispredict=1 -> next cycle pc_i=0x100 gives hit=1, taken=1, next_pc=0x80; br_cnt_o=1, mispred_cnt_o=1.
- Counter saturation from cnt=2:
  - Not-taken x3 gives cnt 1, 0, 0; taken=0 after the first, hit stays 1, next_pc=0x104.
  - Taken x4 gives cnt 1, 2, 3, 3; taken=1 from the second.
- Alias: with 0x100 allocated, update pc=0x200 (same idx 0, tag 0x02), taken, target 0x300 -> pc_i=0x200 hits with next_pc 0x300; pc_i=0x100 now misses with next_pc 0x104.
- Same cycle, pc_i=0x100, update of 0x100 not-taken while cnt=2 -> this cycle taken=1; next cycle taken=0.
- Flush and update of 0x400 taken in the same cycle -> all lookups miss afterwards; br_cnt_o still increments. Asynchronous reset pulsed mid-cycle -> outputs revert immediately with no clock edge.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target buffer.
// Holds the default widths, counter helper functions, counter state
// constants and the table entry payload type.
package bp_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned ENTRIES_DEF = 64;
  localparam int unsigned TAG_W_DEF   = 8;
  localparam int unsigned CNT_W_DEF   = 2;
  localparam int unsigned PERF_W_DEF  = 32;

  // Ceiling log2, for table index width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

  // Saturating increment of a w-bit counter held in the low bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned w);
    logic [31:0] mx;
    mx = 32'((64'd1 << w) - 64'd1);
    return (cnt >= mx) ? mx : cnt + 32'd1;
  endfunction

  // Saturating decrement, floor 0.
  function automatic logic [31:0] sat_dec(input logic [31:0] cnt, input int unsigned w);
    logic [31:0] unused_w;
    unused_w = 32'(w);
    return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
  endfunction

  // Weakly-taken / weakly-not-taken encodings for a w-bit counter.
  function automatic logic [31:0] weak_t(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic logic [31:0] weak_nt(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  localparam logic [CNT_W_DEF-1:0] CNT_WEAK_T  = CNT_W_DEF'(weak_t(CNT_W_DEF));
  localparam logic [CNT_W_DEF-1:0] CNT_WEAK_NT = CNT_W_DEF'(weak_nt(CNT_W_DEF));

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]  target;
    logic [CNT_W_DEF-1:0] cnt;
  } entry_t;

endpackage

// File: rtl/bp_table.sv
// BTB storage array.
// Ports: clk/rst (async, active-high); clr_valid clears every valid bit;
// rd_* combinational lookup port; up_* combinational read of the entry
// being updated; wr_* single synchronous write port (sets valid).
module bp_table
  import bp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_valid,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [XLEN-1:0]  rd_target,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic [IDX_W-1:0] up_idx,
  output logic             up_valid,
  output logic [TAG_W-1:0] up_tag,
  output logic [XLEN-1:0]  up_target,
  output logic [CNT_W-1:0] up_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_target,
  input  logic [CNT_W-1:0] wr_cnt
);

  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(weak_nt(CNT_W));

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];

  // Read ports see registered state only (no write bypass).
  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_cnt    = cnt_q[rd_idx];
  assign up_valid  = valid_q[up_idx];
  assign up_tag    = tag_q[up_idx];
  assign up_target = target_q[up_idx];
  assign up_cnt    = cnt_q[up_idx];

  // Payload write; a clear in the same cycle still wins on valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_RST;
      end
    end else begin
      if (wr_en) begin
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= wr_target;
        cnt_q[wr_idx]    <= wr_cnt;
      end
      if (clr_valid)  valid_q         <= '0;
      else if (wr_en) valid_q[wr_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Ports: clk_i/rst_i (async, active-high); flush_i invalidates all entries;
// pc_i lookup with zero-latency pred_hit_o/pred_taken_o/pred_next_pc_o;
// upd_* resolved-branch update from ID; br_cnt_o/mispred_cnt_o wrapping
// performance counters.
module bp_btb
  import bp_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned ENTRIES = ENTRIES_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned PERF_W  = PERF_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_next_pc_o,
  input  logic              upd_valid_i,
  input  logic [XLEN-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [XLEN-1:0]   upd_target_i,
  input  logic              upd_mispredict_i,
  output logic [PERF_W-1:0] br_cnt_o,
  output logic [PERF_W-1:0] mispred_cnt_o
);

  localparam int unsigned IDX_W = clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(weak_t(CNT_W));

  logic [IDX_W-1:0] idx, upd_idx;
  logic [TAG_W-1:0] tag, upd_tag;
  logic             rd_valid, up_valid;
  logic [TAG_W-1:0] rd_tag, up_tag;
  logic [XLEN-1:0]  rd_target, up_target;
  logic [CNT_W-1:0] rd_cnt, up_cnt;
  logic             upd_hit;
  logic             wr_en;
  logic [XLEN-1:0]  wr_target;
  logic [CNT_W-1:0] wr_cnt;
  logic             unused_upd_pc;

  assign idx     = pc_i[IDX_W+1:2];
  assign tag     = pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_upd_pc = &{1'b0, upd_pc_i};

  bp_table #(
    .XLEN    (XLEN),
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W),
    .CNT_W   (CNT_W)
  ) u_table (
    .clk       (clk_i),
    .rst       (rst_i),
    .clr_valid (flush_i),
    .rd_idx    (idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_cnt    (rd_cnt),
    .up_idx    (upd_idx),
    .up_valid  (up_valid),
    .up_tag    (up_tag),
    .up_target (up_target),
    .up_cnt    (up_cnt),
    .wr_en     (wr_en),
    .wr_idx    (upd_idx),
    .wr_tag    (upd_tag),
    .wr_target (wr_target),
    .wr_cnt    (wr_cnt)
  );

  // Lookup and next-PC mux.
  assign pred_hit_o     = rd_valid && (rd_tag == tag);
  assign pred_taken_o   = pred_hit_o && rd_cnt[CNT_W-1];
  assign pred_next_pc_o = pred_taken_o ? rd_target : pc_i + XLEN'(4);

  // Update policy: train on hit, allocate only on a taken miss.
  always_comb begin
    upd_hit   = up_valid && (up_tag == upd_tag);
    wr_en     = 1'b0;
    wr_target = upd_target_i;
    wr_cnt    = CNT_ALLOC;
    if (upd_valid_i) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_taken_i) begin
          wr_cnt = CNT_W'(sat_inc(32'(up_cnt), CNT_W));
        end else begin
          wr_cnt    = CNT_W'(sat_dec(32'(up_cnt), CNT_W));
          wr_target = up_target;
        end
      end else if (upd_taken_i) begin
        wr_en = 1'b1;
      end
    end
  end

  // Wrapping performance counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_cnt_o      <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (upd_valid_i)                     br_cnt_o      <= br_cnt_o + PERF_W'(1);
      if (upd_valid_i && upd_mispredict_i) mispred_cnt_o <= mispred_cnt_o + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_bp_btb.sv
// Directed self-checking bench for bp_btb (default parameters:
// idx = pc[7:2], tag = pc[15:8], 2-bit counters).
module tb_bp_btb;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] pc;
  logic        hit;
  logic        taken;
  logic [31:0] next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mis;
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_br   = 0;
  int exp_mis  = 0;

  bp_btb dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .pc_i             (pc),
    .pred_hit_o       (hit),
    .pred_taken_o     (taken),
    .pred_next_pc_o   (next_pc),
    .upd_valid_i      (upd_valid),
    .upd_pc_i         (upd_pc),
    .upd_taken_i      (upd_taken),
    .upd_target_i     (upd_target),
    .upd_mispredict_i (upd_mis),
    .br_cnt_o         (br_cnt),
    .mispred_cnt_o    (mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] p, input logic eh,
                      input logic et, input logic [31:0] enp);
    pc = p;
    #1;
    chk({tag, "_hit"}, 32'(hit), 32'(eh));
    chk({tag, "_taken"}, 32'(taken), 32'(et));
    chk({tag, "_next_pc"}, next_pc, enp);
  endtask

  task automatic perf(input string tag);
    chk({tag, "_br_cnt"}, br_cnt, 32'(exp_br));
    chk({tag, "_mis_cnt"}, mis_cnt, 32'(exp_mis));
  endtask

  // One resolved branch applied over one clock edge.
  task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tgt, input logic m);
    upd_valid  = 1'b1;
    upd_pc     = p;
    upd_taken  = t;
    upd_target = tgt;
    upd_mis    = m;
    tick();
    upd_valid = 1'b0;
    upd_mis   = 1'b0;
    exp_br++;
    if (m) exp_mis++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; pc = 32'h100;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mis = 1'b0;
    tick();
    tick();
    look("rst_lookup", 32'h100, 1'b0, 1'b0, 32'h104);
    perf("rst");
    rst = 1'b0;
    tick();
    look("post_rst", 32'h100, 1'b0, 1'b0, 32'h104);
    look("pc_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // Allocate 0x100 -> 0x80, counter weakly taken (2).
    upd(32'h100, 1'b1, 32'h80, 1'b1);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h80);
    perf("alloc");

    // Not-taken x3: 1, 0, 0.
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("nt2", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("nt3", 32'h100, 1'b1, 1'b0, 32'h104);

    // Taken x4: 1, 2, 3, 3; last one retargets to 0x90.
    upd(32'h100, 1'b1, 32'h80, 1'b1);
    look("t1", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h80, 1'b1);
    look("t2", 32'h100, 1'b1, 1'b1, 32'h80);
    upd(32'h100, 1'b1, 32'h80, 1'b0);
    look("t3", 32'h100, 1'b1, 1'b1, 32'h80);
    upd(32'h100, 1'b1, 32'h90, 1'b0);
    look("t4_retarget", 32'h100, 1'b1, 1'b1, 32'h90);
    perf("train");

    // From saturated 3: not-taken gives 2 (taken), then 1 (not taken).
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("sat_nt1", 32'h100, 1'b1, 1'b1, 32'h90);
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    look("sat_nt2", 32'h100, 1'b1, 1'b0, 32'h104);

    // Miss not-taken leaves the table alone.
    upd(32'h204, 1'b0, 32'h700, 1'b0);
    look("miss_nt", 32'h204, 1'b0, 1'b0, 32'h208);

    // Alias on idx 0: 0x200 replaces 0x100.
    upd(32'h200, 1'b1, 32'h300, 1'b0);
    look("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);

    // Same-cycle lookup and update: no bypass.
    upd(32'h100, 1'b1, 32'h80, 1'b1);
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b0; upd_mis = 1'b1;
    look("same_cyc_pre", 32'h100, 1'b1, 1'b1, 32'h80);
    tick();
    upd_valid = 1'b0; upd_mis = 1'b0;
    exp_br++; exp_mis++;
    look("same_cyc_post", 32'h100, 1'b1, 1'b0, 32'h104);

    // Flush with simultaneous allocate of 0x400.
    upd(32'h104, 1'b1, 32'h40, 1'b0);
    look("pre_flush", 32'h104, 1'b1, 1'b1, 32'h40);
    flush = 1'b1;
    upd(32'h400, 1'b1, 32'h500, 1'b0);
    flush = 1'b0;
    look("flush_upd", 32'h400, 1'b0, 1'b0, 32'h404);
    look("flush_other", 32'h104, 1'b0, 1'b0, 32'h108);
    look("flush_old", 32'h100, 1'b0, 1'b0, 32'h104);
    perf("flush");

    // Asynchronous reset mid-cycle, then an update as reset drops.
    upd(32'h104, 1'b1, 32'h44, 1'b1);
    look("pre_async", 32'h104, 1'b1, 1'b1, 32'h44);
    #2;
    rst = 1'b1;
    exp_br = 0; exp_mis = 0;
    look("async_rst", 32'h104, 1'b0, 1'b0, 32'h108);
    perf("async_rst");
    rst = 1'b0;
    upd(32'h108, 1'b1, 32'h88, 1'b1);
    look("rst_release_upd", 32'h108, 1'b1, 1'b1, 32'h88);
    perf("rst_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
